// File: rtl/fht_but_feed.sv
// Feeder between a tuple stream and an external Hartley butterfly: 4-deep input FIFO,
// operand staging that skews x0 one cycle behind x1/x2/twiddle, and a 4-deep result FIFO.
module fht_but_feed #(
   parameter int D_BIT = 18,
   parameter int W_BIT = 16,
   parameter int A_BIT = 10
) (
   input  logic                    iCLK,
   input  logic                    iRESET,
   input  logic                    iVALID,
   output logic                    oREADY,
   input  logic signed [D_BIT-1:0] iX_0,
   input  logic signed [D_BIT-1:0] iX_1,
   input  logic signed [D_BIT-1:0] iX_2,
   input  logic signed [W_BIT-1:0] iSIN,
   input  logic signed [W_BIT-1:0] iCOS,
   input  logic        [A_BIT-1:0] iADDR_0,
   input  logic        [A_BIT-1:0] iADDR_1,
   output logic signed [D_BIT-1:0] oX_0,
   output logic signed [D_BIT-1:0] oX_1,
   output logic signed [D_BIT-1:0] oX_2,
   output logic signed [W_BIT-1:0] oSIN,
   output logic signed [W_BIT-1:0] oCOS,
   input  logic signed [D_BIT-1:0] iY_0,
   input  logic signed [D_BIT-1:0] iY_1,
   output logic                    oVALID,
   input  logic                    iREADY,
   output logic signed [D_BIT-1:0] oY_0,
   output logic signed [D_BIT-1:0] oY_1,
   output logic        [A_BIT-1:0] oADDR_0,
   output logic        [A_BIT-1:0] oADDR_1
);

   typedef struct packed {
      logic [D_BIT-1:0] x0;
      logic [D_BIT-1:0] x1;
      logic [D_BIT-1:0] x2;
      logic [W_BIT-1:0] s;
      logic [W_BIT-1:0] c;
      logic [A_BIT-1:0] a0;
      logic [A_BIT-1:0] a1;
   } tuple_t;

   typedef struct packed {
      logic [D_BIT-1:0] y0;
      logic [D_BIT-1:0] y1;
      logic [A_BIT-1:0] a0;
      logic [A_BIT-1:0] a1;
   } result_t;

   tuple_t           in_mem [4];
   tuple_t           tuple_in;
   logic [1:0]       in_wp, in_rp;
   logic [2:0]       in_cnt;

   result_t          res_mem [4];
   result_t          res_head;
   logic [1:0]       res_wp, res_rp;
   logic [2:0]       res_cnt;

   logic [2:0]       credit;
   logic             in_push, issue, res_push, res_pop, res_valid, credit_ok;

   tuple_t           sa;
   logic             va;
   logic [D_BIT-1:0] sb_x0;
   logic [A_BIT-1:0] sb_a0, sb_a1;
   logic             vb;
   logic [A_BIT-1:0] sc_a0, sc_a1;
   logic             vc;

   assign tuple_in = {iX_0, iX_1, iX_2, iSIN, iCOS, iADDR_0, iADDR_1};

   // A result leaving this edge frees its credit for a tuple issued at the same edge,
   // which is what keeps one tuple per cycle flowing with a 4-credit window.
   always_comb begin
      res_valid = (res_cnt != 3'd0);
      res_pop   = res_valid & iREADY;
      credit_ok = (credit < 3'd4) | res_pop;
      issue     = (in_cnt != 3'd0) & credit_ok;
      oREADY    = iRESET & ((in_cnt != 3'd4) | issue);
      in_push   = iVALID & oREADY;
      res_push  = vc;
   end

   always_ff @(posedge iCLK) begin
      if (in_push) in_mem[in_wp] <= tuple_in;
      if (res_push) res_mem[res_wp] <= {iY_0, iY_1, sc_a0, sc_a1};
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         in_wp   <= 2'd0;
         in_rp   <= 2'd0;
         in_cnt  <= 3'd0;
         res_wp  <= 2'd0;
         res_rp  <= 2'd0;
         res_cnt <= 3'd0;
         credit  <= 3'd0;
      end else begin
         in_wp   <= in_wp + 2'(in_push);
         in_rp   <= in_rp + 2'(issue);
         in_cnt  <= in_cnt + 3'(in_push) - 3'(issue);
         res_wp  <= res_wp + 2'(res_push);
         res_rp  <= res_rp + 2'(res_pop);
         res_cnt <= res_cnt + 3'(res_push) - 3'(res_pop);
         credit  <= credit + 3'(issue) - 3'(res_pop);
      end
   end

   // Stage A drives x1/x2/twiddle, stage B drives x0 a cycle later, stage C
   // carries the tags to the edge where the butterfly result is captured.
   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         sa    <= '0;
         va    <= 1'b0;
         sb_x0 <= '0;
         sb_a0 <= '0;
         sb_a1 <= '0;
         vb    <= 1'b0;
         sc_a0 <= '0;
         sc_a1 <= '0;
         vc    <= 1'b0;
      end else begin
         va <= issue;
         if (issue) sa <= in_mem[in_rp];
         vb    <= va;
         sb_x0 <= sa.x0;
         sb_a0 <= sa.a0;
         sb_a1 <= sa.a1;
         vc    <= vb;
         sc_a0 <= sb_a0;
         sc_a1 <= sb_a1;
      end
   end

   always_comb begin
      res_head = res_mem[res_rp];
      oX_1     = va ? sa.x1 : '0;
      oX_2     = va ? sa.x2 : '0;
      oSIN     = va ? sa.s  : '0;
      oCOS     = va ? sa.c  : '0;
      oX_0     = vb ? sb_x0 : '0;
      oVALID   = res_valid;
      oY_0     = res_valid ? res_head.y0 : '0;
      oY_1     = res_valid ? res_head.y1 : '0;
      oADDR_0  = res_valid ? res_head.a0 : '0;
      oADDR_1  = res_valid ? res_head.a1 : '0;
   end

endmodule

// File: tb/tb_fht_but_feed.sv
// Bench for fht_but_feed: a behavioural butterfly closes the loop and a scoreboard
// predicts every result from the accepted tuples.
module tb_fht_but_feed;
   localparam int D = 18;
   localparam int W = 16;
   localparam int A = 10;

   logic                iCLK = 1'b0;
   logic                iRESET = 1'b0;
   logic                iVALID = 1'b0;
   logic                oREADY;
   logic signed [D-1:0] iX_0 = '0, iX_1 = '0, iX_2 = '0;
   logic signed [W-1:0] iSIN = '0, iCOS = '0;
   logic        [A-1:0] iADDR_0 = '0, iADDR_1 = '0;
   logic signed [D-1:0] oX_0, oX_1, oX_2;
   logic signed [W-1:0] oSIN, oCOS;
   logic        [D-1:0] iY_0 = '0, iY_1 = '0;
   logic                oVALID;
   logic                iREADY = 1'b0;
   logic        [D-1:0] oY_0, oY_1;
   logic        [A-1:0] oADDR_0, oADDR_1;

   fht_but_feed #(.D_BIT(D), .W_BIT(W), .A_BIT(A)) dut (
      .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID), .oREADY(oREADY),
      .iX_0(iX_0), .iX_1(iX_1), .iX_2(iX_2), .iSIN(iSIN), .iCOS(iCOS),
      .iADDR_0(iADDR_0), .iADDR_1(iADDR_1),
      .oX_0(oX_0), .oX_1(oX_1), .oX_2(oX_2), .oSIN(oSIN), .oCOS(oCOS),
      .iY_0(iY_0), .iY_1(iY_1), .oVALID(oVALID), .iREADY(iREADY),
      .oY_0(oY_0), .oY_1(oY_1), .oADDR_0(oADDR_0), .oADDR_1(oADDR_1)
   );

   always #5 iCLK = ~iCLK;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // Butterfly arithmetic: p = (x1*cos + x2*sin) >> (W-1), y0/y1 = (x0 +/- p) >> 1
   function automatic longint calc_p(input longint x1, input longint x2,
                                     input longint s, input longint c);
      return (x1 * c + x2 * s) >>> (W - 1);
   endfunction

   function automatic logic [D-1:0] calc_y(input longint x0, input longint p, input bit neg);
      longint t;
      t = neg ? (x0 - p) : (x0 + p);
      return D'(t >>> 1);
   endfunction

   // Attached butterfly: product registered after cycle c, sums registered after c+1
   longint bf_p = 0;
   always @(posedge iCLK) begin
      bf_p <= calc_p(oX_1, oX_2, oSIN, oCOS);
      iY_0 <= calc_y(oX_0, bf_p, 1'b0);
      iY_1 <= calc_y(oX_0, bf_p, 1'b1);
   end

   typedef struct {
      logic [D-1:0] y0;
      logic [D-1:0] y1;
      logic [A-1:0] a0;
      logic [A-1:0] a1;
      bit           approx;
      longint       x0;
      longint       x1;
   } exp_t;

   exp_t exp_q[$];
   bit   approx_mode = 1'b0;
   int   cyc = 0;
   int   pop_n = 0, pop_first = -1, pop_last = -1;

   always @(negedge iCLK) begin
      exp_t   e, ne;
      longint p, sy, err;
      cyc++;
      if (!iRESET) begin
         exp_q.delete();
      end else begin
         if (oVALID) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL stale_result: got oVALID=1 tag %0d, required no result pending", oADDR_0);
            end else begin
               e = exp_q[0];
               check("res_y0", oY_0, e.y0);
               check("res_y1", oY_1, e.y1);
               check("res_addr0", oADDR_0, e.a0);
               check("res_addr1", oADDR_1, e.a1);
               if (e.approx) begin
                  sy  = $signed(oY_0);
                  err = 2 * sy - (e.x0 + e.x1);
                  if (err < 0) err = -err;
                  n_tests++;
                  if (err > 2) begin
                     n_fail++;
                     $display("FAIL approx_y0: got %0d, required (%0d)/2 within 1", sy, e.x0 + e.x1);
                  end
                  sy  = $signed(oY_1);
                  err = 2 * sy - (e.x0 - e.x1);
                  if (err < 0) err = -err;
                  n_tests++;
                  if (err > 2) begin
                     n_fail++;
                     $display("FAIL approx_y1: got %0d, required (%0d)/2 within 1", sy, e.x0 - e.x1);
                  end
               end
               if (iREADY) begin
                  void'(exp_q.pop_front());
                  if (pop_first < 0) pop_first = cyc;
                  pop_last = cyc;
                  pop_n++;
               end
            end
         end
         if (iVALID && oREADY) begin
            p         = calc_p(iX_1, iX_2, iSIN, iCOS);
            ne.y0     = calc_y(iX_0, p, 1'b0);
            ne.y1     = calc_y(iX_0, p, 1'b1);
            ne.a0     = iADDR_0;
            ne.a1     = iADDR_1;
            ne.approx = approx_mode;
            ne.x0     = iX_0;
            ne.x1     = iX_1;
            exp_q.push_back(ne);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input longint x0, input longint x1, input longint x2,
                       input longint s, input longint c, input longint a0,
                       input longint a1, output int tries);
      bit acc;
      iX_0    = D'(x0);
      iX_1    = D'(x1);
      iX_2    = D'(x2);
      iSIN    = W'(s);
      iCOS    = W'(c);
      iADDR_0 = A'(a0);
      iADDR_1 = A'(a1);
      iVALID  = 1'b1;
      tries   = 0;
      acc     = 1'b0;
      while (!acc && tries < 100) begin
         @(negedge iCLK);
         acc = oREADY;
         tries++;
         @(posedge iCLK);
         #1;
      end
      iVALID = 1'b0;
      if (!acc) check("send_accept_timeout", 0, 1);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge iCLK);
         #1;
         done = (exp_q.size() == 0);
      end
      check("drain_pending", exp_q.size(), 0);
      @(posedge iCLK);
      #1;
   endtask

   // Idle block: accept edge, pop to A, A->B, B->C, capture; oVALID is seen in the
   // cycle after the fifth of those edges (index 4 counted from the accept edge).
   task automatic directed(input longint x0, input longint x1, input longint x2,
                           input longint s, input longint c, input longint a0,
                           input longint a1, input longint ey0, input longint ey1);
      int tr, first_v;
      iREADY  = 1'b1;
      first_v = -1;
      send(x0, x1, x2, s, c, a0, a1, tr);
      for (int i = 0; i < 8; i++) begin
         @(negedge iCLK);
         if (i == 1) begin
            check("cyc_c_x1", oX_1, x1);
            check("cyc_c_x2", oX_2, x2);
            check("cyc_c_sin", oSIN, s);
            check("cyc_c_cos", oCOS, c);
            check("cyc_c_x0_idle", oX_0, 0);
         end
         if (i == 2) begin
            check("cyc_c1_x0", oX_0, x0);
            check("cyc_c1_x1_idle", oX_1, 0);
         end
         if (oVALID && first_v < 0) begin
            first_v = i;
            check("lit_y0", oY_0, ey0);
            check("lit_y1", oY_1, ey1);
            check("lit_addr0", oADDR_0, a0);
            check("lit_addr1", oADDR_1, a1);
         end
      end
      check("latency", first_v, 4);
      @(posedge iCLK);
      #1;
   endtask

   initial begin
      int tr, nv;
      longint x0, x1, x2;

      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      check("rst_ready", oREADY, 0);
      check("rst_valid", oVALID, 0);
      check("rst_x0", oX_0, 0);
      check("rst_y0", oY_0, 0);
      @(posedge iCLK);
      #1;
      iRESET = 1'b1;
      @(negedge iCLK);
      check("ready_after_reset", oREADY, 1);
      @(posedge iCLK);
      #1;

      directed(18'h01000, 18'h00800, 18'h00800, 0, 0, 5, 6, 18'h00800, 18'h00800);
      // p = (0x40*0x4000 + 0x20*0x2000) >> 15 = 0x28; y0 = 0x128>>1, y1 = 0xD8>>1
      directed(18'h00100, 18'h00040, 18'h00020, 16'h2000, 16'h4000, 7, 8, 18'h00094, 18'h0006C);

      // streaming
      iREADY = 1'b1;
      pop_n = 0; pop_first = -1; pop_last = -1;
      for (int i = 0; i < 16; i++) begin
         send(i * 1000 - 7000, 3000 - i * 333, i * 111, i * 1000 - 5000,
              20000 - i * 900, i, 1023 - i, tr);
         check("stream_ready", tr, 1);
      end
      drain();
      check("stream_count", pop_n, 16);
      check("stream_contiguous", pop_last - pop_first, 15);

      // backpressure: 4 credits fill the result FIFO, 4 more fill the input FIFO
      iREADY = 1'b0;
      pop_n = 0;
      for (int i = 0; i < 8; i++) begin
         send(500 + i * 77, -(i * 250), 1200 - i * 99, 3000 + i, -12000 + i * 5,
              100 + i, 200 + i, tr);
         check("bp_accept", tr, 1);
      end
      repeat (6) @(posedge iCLK);
      @(negedge iCLK);
      check("bp_ready_low", oREADY, 0);
      check("bp_valid", oVALID, 1);
      check("bp_head_tag", oADDR_0, 100);
      check("bp_pipe_empty", oX_1, 0);
      @(posedge iCLK);
      #1;
      iREADY = 1'b1;
      send(900, 40, -30, 111, 222, 108, 208, tr);
      check("full_push_pop_ready", tr, 1);
      send(-900, -40, 30, -111, -222, 109, 209, tr);
      check("bp_tail_ready", tr, 1);
      drain();
      check("bp_count", pop_n, 10);

      // reset with three tuples in flight
      for (int i = 0; i < 3; i++) send(4000 + i, 300 + i, 20 + i, 5000, 6000, 40 + i, 50 + i, tr);
      #2;
      iRESET = 1'b0;
      #1;
      check("midrst_ready", oREADY, 0);
      check("midrst_valid", oVALID, 0);
      check("midrst_x0", oX_0, 0);
      check("midrst_x1", oX_1, 0);
      check("midrst_x2", oX_2, 0);
      check("midrst_sin", oSIN, 0);
      check("midrst_cos", oCOS, 0);
      check("midrst_y0", oY_0, 0);
      check("midrst_addr0", oADDR_0, 0);
      repeat (2) @(posedge iCLK);
      #1;
      iRESET = 1'b1;
      nv = 0;
      @(negedge iCLK);
      check("midrst_ready_after", oREADY, 1);
      for (int i = 0; i < 8; i++) begin
         @(negedge iCLK);
         if (oVALID) nv++;
      end
      check("midrst_no_stale", nv, 0);
      @(posedge iCLK);
      #1;
      directed(18'h00200, 18'h00100, 18'h00000, 16'h0000, 16'h4000, 9, 10, 18'h00140, 18'h000C0);

      // closed loop: cos = MAX_W, sin = 0
      approx_mode = 1'b1;
      iREADY = 1'b1;
      for (int i = 0; i < 20; i++) begin
         x0 = longint'($urandom_range(0, 65535)) - 32768;
         x1 = longint'($urandom_range(0, 65535)) - 32768;
         x2 = longint'($urandom_range(0, 65535)) - 32768;
         send(x0, x1, x2, 0, 32767, i + 300, i + 600, tr);
      end
      drain();
      approx_mode = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/fht_but_feed.md
FHT_BUT_FEED -- requirements
Module: fht_but_feed

Interface
REQ-001 SHALL have parameter D_BIT, default 18: data word width, same fixed-point format as the butterfly data ports.
REQ-002 SHALL have parameter W_BIT, default 16: twiddle coefficient width.
REQ-003 SHALL have parameter A_BIT, default 10: write-back address tag width.
REQ-004 SHALL have a port iCLK  in  1  single clock, all state on its rising edge.
REQ-005 SHALL have a port iRESET  in  1  asynchronous, active-low reset.
REQ-006 SHALL have a port iVALID  in  1  upstream tuple valid.
REQ-007 SHALL have a port oREADY  out  1  input FIFO not full.
REQ-008 SHALL have ports iX_0, iX_1, iX_2  in  D_BIT each  signed operands of one tuple.
REQ-009 SHALL have ports iSIN, iCOS  in  W_BIT each  signed twiddle of one tuple.
REQ-010 SHALL have ports iADDR_0, iADDR_1  in  A_BIT each  write-back addresses for y0 and y1.
REQ-011 SHALL have ports oX_0, oX_1, oX_2  out  D_BIT each  butterfly operand drive.
REQ-012 SHALL have ports oSIN, oCOS  out  W_BIT each  butterfly coefficient drive.
REQ-013 SHALL have ports iY_0, iY_1  in  D_BIT each  butterfly results.
REQ-014 SHALL have a port oVALID  out  1  result buffer head valid.
REQ-015 SHALL have a port iREADY  in  1  downstream accepts the result.
REQ-016 SHALL have ports oY_0, oY_1  out  D_BIT each, and oADDR_0, oADDR_1  out  A_BIT each  result with its tags.

Function
REQ-017 SHALL accept a tuple at each edge where iVALID and oREADY are both 1, and SHALL write it into a 4-entry input FIFO.
REQ-018 SHALL drive oREADY = 1 whenever the input FIFO holds fewer than 4 entries, including at the same edge as a pop.
REQ-019 SHALL pop a tuple at an edge only when the FIFO is non-empty and the credit count is below 4.
REQ-020 SHALL define the credit count as tuples issued but not yet in the result buffer, plus result buffer occupancy, with a maximum of 4.
REQ-021 SHALL register a popped tuple into stage A, and SHALL drive oX_1, oX_2, oSIN and oCOS from stage A during the following cycle (cycle c).
REQ-022 SHALL drive oX_0 of the same tuple during cycle c+1 from stage B, so that oX_0 of tuple n coexists with oX_1 of tuple n+1.
REQ-023 SHALL sample iY_0 and iY_1 at the end of cycle c+2 and SHALL write them, with the tuple's iADDR_0 and iADDR_1 carried through the stages, into a 4-entry result FIFO.
REQ-024 SHALL, when no tuple is in a stage, drive that stage's oX_*, oSIN and oCOS outputs to 0.
REQ-025 SHALL sustain one tuple per cycle while iREADY = 1, with a latency of 5 edges from accept to oVALID for an idle block.
REQ-026 SHALL present the result head on oVALID, oY_* and oADDR_*, SHALL remove it at an edge with oVALID = 1 and iREADY = 1, and SHALL hold it stable while iREADY = 0.
REQ-027 SHALL let the result FIFO push and pop in the same edge, leaving occupancy unchanged.
REQ-028 SHALL let the input FIFO push and pop in the same edge, including when it is full and a pop frees an entry.
REQ-029 SHALL guarantee the result FIFO never overflows, by means of the credit rule alone.
REQ-030 SHALL pass data through without modification and without arithmetic.
REQ-031 SHALL deliver results in the order of acceptance.

Reset
REQ-032 SHALL, when iRESET = 0, immediately clear both FIFOs, the stage valid bits and the credit count.
REQ-033 SHALL, while iRESET = 0, hold all data outputs at 0, oVALID = 0 and oREADY = 0.
REQ-034 SHALL drive oREADY = 1 in the first cycle after iRESET returns to 1.
REQ-035 SHALL discard all in-flight tuples on reset asserted mid-operation, produce no stale oVALID afterwards, and drop any iY arriving after deassertion.

Verification
REQ-036 SHALL cover single tuple: x1=x2=0x00800, sin=cos=0 and x0=0x01000 with addr 5/6 -> oX_1 at cycle c, oX_0 at c+1, oVALID 5 edges after accept, oADDR=5/6.
REQ-037 SHALL cover streaming: 16 tuples back-to-back with iREADY=1 -> oREADY stays 1, 16 results on consecutive cycles in order, tags 0..15 intact.
REQ-038 SHALL cover backpressure: iREADY=0 while feeding 10 tuples -> exactly 4 results buffered, input FIFO fills, oREADY=0 after 8 accepted; releasing iREADY drains all 10 in order.
REQ-039 SHALL cover a full input FIFO with a simultaneous push and pop -> oREADY stays 1, no tuple is lost or duplicated.
REQ-040 SHALL cover reset mid-stream: iRESET=0 with 3 tuples in flight -> outputs 0 at once; after release, no oVALID until new tuples arrive, then 5-edge latency.
REQ-041 SHALL cover a closed loop with fht_but attached: random x within the data range, cos = MAX_W and sin = 0 -> oY_0 = (x0+x1)/2 and oY_1 = (x0-x1)/2 within 1 LSB.
